mac_array_ctrl: RTL and testbench

- Sequencer for the 4-lane MAC array: issues activation/weight SRAM reads chunk by chunk (4 lanes per chunk) and closes the psum loop around the combinational array through its own accumulator.
- Presents one finished dot product per output channel on a valid/ready port.
- Sits between the x/w SRAMs, the MAC array and the output psum SRAM writer.

---
 rtl/mac_array_ctrl.sv | 102 ++++++++++
 tb/tb_mac_array_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: steps x/w SRAM reads chunk by chunk and accumulates MAC array psums into one result per output channel.
module mac_array_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int cw      = 5,
    parameter int ow      = 4,
    parameter int xaw     = 5,
    parameter int waw     = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [cw-1:0]      k_chunks,
    input  logic [ow-1:0]      n_out,
    output logic               busy,
    output logic               done,
    output logic               x_rd_en,
    output logic [xaw-1:0]     x_addr,
    output logic               w_rd_en,
    output logic [waw-1:0]     w_addr,
    output logic [psum_bw-1:0] acc_in,
    input  logic [psum_bw-1:0] acc_out,
    output logic               out_valid,
    output logic [psum_bw-1:0] out_data,
    output logic [ow-1:0]      out_idx,
    input  logic               out_ready
);
    if (psum_bw < 2 * bw) begin : g_width_check
        $error("psum_bw too narrow for lane products");
    end

    typedef enum logic [2:0] {IDLE, RUN, WAIT, OUT, FIN} state_t;
    state_t state, state_n;

    logic [cw-1:0]      k_reg, chunk;
    logic [ow-1:0]      n_reg;
    logic [waw-1:0]     w_base;
    logic [psum_bw-1:0] acc_reg;
    logic               v_d, first_d, last_d;
    logic               last_chunk, last_out, cfg_zero;

    assign last_chunk = chunk + cw'(1) == k_reg;
    assign last_out   = out_idx + ow'(1) == n_reg;
    assign cfg_zero   = k_chunks == '0 || n_out == '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = cfg_zero ? FIN : RUN;
            RUN:     if (last_chunk) state_n = WAIT;
            WAIT:    state_n = OUT;
            OUT:     if (out_ready) state_n = last_out ? FIN : RUN;
            default: state_n = IDLE;
        endcase
    end

    assign busy      = state != IDLE;
    assign done      = state == FIN;
    assign x_rd_en   = state == RUN;
    assign w_rd_en   = x_rd_en;
    assign out_valid = state == OUT;
    assign x_addr    = xaw'(chunk);
    assign w_addr    = w_base + waw'(chunk);
    // Read data lands a cycle after the address, so the psum loop runs one stage behind.
    assign acc_in    = first_d ? '0 : acc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            k_reg    <= '0;
            n_reg    <= '0;
            chunk    <= '0;
            out_idx  <= '0;
            w_base   <= '0;
            acc_reg  <= '0;
            out_data <= '0;
            v_d      <= 1'b0;
            first_d  <= 1'b0;
            last_d   <= 1'b0;
        end else begin
            state   <= state_n;
            v_d     <= x_rd_en;
            first_d <= x_rd_en && chunk == '0;
            last_d  <= x_rd_en && last_chunk;
            if (v_d) acc_reg <= acc_out;
            if (v_d && last_d) out_data <= acc_out;
            if (state == IDLE && start) begin
                k_reg   <= k_chunks;
                n_reg   <= n_out;
                chunk   <= '0;
                out_idx <= '0;
                w_base  <= '0;
            end else if (x_rd_en && !last_chunk) begin
                chunk <= chunk + cw'(1);
            end else if (out_valid && out_ready && !last_out) begin
                out_idx <= out_idx + ow'(1);
                w_base  <= w_base + waw'(k_reg);
                chunk   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: drives mac_array_ctrl against modelled SRAMs and a MAC array, checking against a dot-product reference.
module tb_mac_array_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
    logic [4:0]  k_chunks = '0;
    logic [3:0]  n_out = '0;
    logic        busy, done, x_rd_en, w_rd_en, out_valid;
    logic [4:0]  x_addr;
    logic [8:0]  w_addr;
    logic [15:0] acc_in, acc_out, out_data;
    logic [3:0]  out_idx;

    logic [15:0] xmem [32];
    logic [15:0] wmem [512];
    logic [15:0] xq, wq, last_data;
    logic [15:0] expv [16];
    int errors = 0, checks = 0;

    mac_array_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .k_chunks(k_chunks), .n_out(n_out),
        .busy(busy), .done(done), .x_rd_en(x_rd_en), .x_addr(x_addr), .w_rd_en(w_rd_en),
        .w_addr(w_addr), .acc_in(acc_in), .acc_out(acc_out), .out_valid(out_valid),
        .out_data(out_data), .out_idx(out_idx), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int dot(input logic [15:0] x, input logic [15:0] w);
        int s = 0;
        for (int l = 0; l < 4; l++) s += int'(x[4*l +: 4]) * int'($signed(w[4*l +: 4]));
        return s;
    endfunction

    always @(posedge clk) begin
        if (x_rd_en) xq <= xmem[x_addr];
        if (w_rd_en) wq <= wmem[w_addr];
    end
    assign acc_out = acc_in + 16'(dot(xq, wq));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input int k, input int n, input int stall, input int mode);
        int cyc, prev_hs, done_cyc, jc, ro, vo, stall_left, bound;
        bit in_valid, zero;
        for (int i = 0; i < 32; i++) xmem[i] = mode == 1 ? 16'h1111 : mode == 2 ? 16'hFFFF : 16'($urandom);
        for (int i = 0; i < 512; i++) wmem[i] = mode == 1 ? 16'h1111 : mode == 2 ? 16'h8888 : 16'($urandom);
        for (int j = 0; j < n; j++) begin
            int s = 0;
            for (int c = 0; c < k; c++) s += dot(xmem[c], wmem[j*k + c]);
            expv[j] = 16'(s);
        end
        zero = k == 0 || n == 0;
        @(posedge clk); #1;
        start = 1'b1; k_chunks = 5'(k); n_out = 4'(n);
        stall_left = stall; out_ready = stall == 0;
        @(posedge clk); #1;
        k_chunks = 5'($urandom); n_out = 4'($urandom);
        cyc = 1; prev_hs = 0; done_cyc = -1; jc = 0; ro = 0; vo = 0; in_valid = 0;
        bound = n * (k + 3 + stall) + 8;
        while (done_cyc < 0 && cyc < bound) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_after_start", busy, 1);
            if (x_rd_en) begin
                if (jc == 0) chk("first_read_cycle", cyc, prev_hs + 1);
                chk("x_addr", x_addr, jc);
                chk("w_addr", w_addr, ro*k + jc);
                chk("w_rd_en", w_rd_en, 1);
                jc++;
                if (jc == k) begin jc = 0; ro++; end
            end
            if (out_valid) begin
                if (!in_valid) chk("valid_cycle", cyc, prev_hs + k + 2);
                in_valid = 1;
                chk("out_data", out_data, expv[vo[3:0]]);
                chk("out_idx", out_idx, vo);
                chk("read_while_valid", x_rd_en, 0);
                if (out_ready) begin
                    last_data = out_data; prev_hs = cyc; vo++; in_valid = 0;
                end else stall_left--;
            end
            if (done) begin
                done_cyc = cyc;
                if (zero) chk("done_early", done_cyc <= 2, 1);
                else chk("done_cycle", cyc, prev_hs + 1);
            end
            @(posedge clk); #1;
            start = 1'b0; out_ready = stall_left <= 0; cyc++;
        end
        chk("done_seen", done_cyc >= 0, 1);
        chk("outputs", vo, zero ? 0 : n);
        chk("read_rows", ro, zero ? 0 : n);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("done_single", done, 0);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rd", {x_rd_en, w_rd_en}, 0);
        chk("rst_out", {out_data, out_idx}, 0);
        chk("rst_acc_in", acc_in, 0);
        @(posedge clk); #1 reset = 1'b0;

        run_job(1, 1, 0, 1);
        chk("ones_sum", last_data, 16'd4);
        run_job(4, 1, 0, 2);
        chk("neg_sum", last_data, 16'hF880);
        run_job(3, 3, 0, 0);
        run_job(2, 2, 5, 0);
        run_job(0, 3, 0, 0);
        run_job(3, 0, 0, 0);
        run_job(31, 2, 0, 0);
        for (int i = 0; i < 5; i++)
            run_job(int'($urandom_range(1, 7)), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 0);

        @(posedge clk); #1;
        start = 1'b1; k_chunks = 5'd4; n_out = 4'd2;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_rd", x_rd_en, 0);
        chk("abort_acc_in", acc_in, 0);
        @(posedge clk); #1 reset = 1'b0;
        run_job(1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
